// File: rtl/loopback_bist.sv
// loopback_bist: built-in self test for a serial loopback path.
// A TX FSM streams NUM_PACKETS packets of PACKET_BYTES bytes (HEADER_BYTE
// followed by (p+k) mod 256) to the serializer. An RX FSM hunts for the header
// in the returned stream, checks the payload against the same pattern, and
// reports mismatches, completed packets and pass/fail.
//
// Ports:
//   clock, reset            sole clock; synchronous active-high reset
//   start                   one-cycle run request (ignored while busy)
//   tx_data/tx_valid/tx_ready  byte stream to the serializer
//   rx_data/rx_valid        returned bytes, no backpressure
//   busy, done, pass        run status; pass is meaningful while done=1
//   error_count, pkt_count  byte mismatches (saturating), packets checked
//   timeout                 run ended by the idle watchdog
//
// Optional feature: define BIST_TIMEOUT_EN to build the RX idle watchdog
// (TIMEOUT_CYCLES). Without it, timeout stays 0 and a run waits forever.
module loopback_bist #(
  parameter int          PACKET_BYTES   = 24,
  parameter int          NUM_PACKETS    = 4,
  parameter logic [7:0]  HEADER_BYTE    = 8'hFF,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] error_count,
  output logic [15:0] pkt_count,
  output logic        timeout
);

  localparam int              KW     = 9;
  localparam logic [KW-1:0]   K_LAST = KW'(PACKET_BYTES - 1);
  localparam logic [15:0]     P_LAST = 16'(NUM_PACKETS - 1);

  typedef enum logic {T_IDLE, T_SEND} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_HUNT, R_CHECK, R_DONE} rx_state_t;

  tx_state_t     tx_state;
  rx_state_t     rx_state;
  logic [KW-1:0] tx_k, rx_k;
  logic [15:0]   tx_p;

  logic        launch, tx_fire, wd_fire, rx_miss;
  logic [7:0]  rx_exp;
  logic [15:0] err_next;

  assign launch  = start && !busy;
  assign tx_fire = tx_valid && tx_ready;
  // pkt_count doubles as the packet index p of the packet being checked
  assign rx_exp  = pkt_count[7:0] + rx_k[7:0];
  assign rx_miss = (rx_state == R_CHECK) && rx_valid && (rx_data != rx_exp);
  // next error count, so the last byte of a run is included in pass
  assign err_next = (rx_miss && error_count != 16'hFFFF) ? error_count + 16'd1
                                                        : error_count;

`ifdef BIST_TIMEOUT_EN
  logic [31:0] wd_cnt;

  always_ff @(posedge clock) begin
    if (reset || launch || rx_valid || !busy) wd_cnt <= '0;
    else                                     wd_cnt <= wd_cnt + 32'd1;
  end

  assign wd_fire = busy && (wd_cnt >= 32'(TIMEOUT_CYCLES));
`else
  assign wd_fire = 1'b0;
`endif

  // TX: a launch restarts the stream from any state
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= T_IDLE;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      tx_k     <= '0;
      tx_p     <= '0;
    end else if (launch) begin
      tx_state <= T_SEND;
      tx_valid <= 1'b1;
      tx_data  <= HEADER_BYTE;
      tx_k     <= '0;
      tx_p     <= '0;
    end else if (wd_fire) begin
      tx_state <= T_IDLE;
      tx_valid <= 1'b0;
    end else begin
      case (tx_state)
        T_SEND: if (tx_fire) begin
          if (tx_k == K_LAST) begin
            if (tx_p == P_LAST) begin
              tx_state <= T_IDLE;
              tx_valid <= 1'b0;
            end else begin
              tx_p    <= tx_p + 16'd1;
              tx_k    <= '0;
              tx_data <= HEADER_BYTE;
            end
          end else begin
            tx_k    <= tx_k + KW'(1);
            tx_data <= tx_p[7:0] + tx_k[7:0] + 8'd1;
          end
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  // RX checker plus run status
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state    <= R_IDLE;
      rx_k        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      error_count <= '0;
      pkt_count   <= '0;
    end else if (launch) begin
      rx_state    <= R_HUNT;
      rx_k        <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      error_count <= '0;
      pkt_count   <= '0;
    end else if (wd_fire) begin
      rx_state <= R_DONE;
      busy     <= 1'b0;
      done     <= 1'b1;
      pass     <= 1'b0;
      timeout  <= 1'b1;
    end else begin
      case (rx_state)
        R_HUNT: if (rx_valid && rx_data == HEADER_BYTE) begin
          rx_state <= R_CHECK;
          rx_k     <= KW'(1);
        end
        R_CHECK: if (rx_valid) begin
          error_count <= err_next;
          if (rx_k == K_LAST) begin
            pkt_count <= pkt_count + 16'd1;
            if (pkt_count == P_LAST) begin
              rx_state <= R_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              pass     <= (err_next == 16'd0) && !timeout;
            end else begin
              rx_state <= R_HUNT;
            end
          end else begin
            rx_k <= rx_k + KW'(1);
          end
        end
        default: ;  // R_IDLE / R_DONE hold until start or reset
      endcase
    end
  end

endmodule

// File: tb/tb_loopback_bist.sv
// Bench for loopback_bist: a 3-cycle loopback delay line feeds tx back to rx,
// with hooks to corrupt, drop or inject bytes. Expected TX bytes and run
// results are queued at stimulus time and popped by a negedge monitor.
module tb_loopback_bist;
  localparam int PB = 24;
  localparam int NP = 4;

  logic        clock = 1'b0, reset = 1'b1, start = 1'b0, tx_ready = 1'b1;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, rx_valid, busy, done, pass, timeout;
  logic [15:0] error_count, pkt_count;

  always #5 clock = ~clock;

  loopback_bist #(.PACKET_BYTES(PB), .NUM_PACKETS(NP), .HEADER_BYTE(8'hFF),
                  .TIMEOUT_CYCLES(50)) dut (
    .clock(clock), .reset(reset), .start(start),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .pkt_count(pkt_count), .timeout(timeout));

  typedef struct { logic p; int err; int pkt; logic to; } res_t;
  logic [7:0] tx_q[$];
  res_t       res_q[$];
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event occurred or missing (got unexpected, required none)", nm);
  endtask

  // loopback delay line with byte index, corruption, drop and injection
  logic       d1_v = 0, d2_v = 0, d3_v = 0, inj_v = 0;
  logic [7:0] d1_d = 0, d2_d = 0, d3_d = 0, inj_d = 0;
  int         d1_i = 0, d2_i = 0, d3_i = 0, tx_n = 0;
  int         corrupt_at = -1, kill_at = 1 << 30;

  always @(posedge clock) begin
    if (start && !busy)          tx_n <= 0;
    else if (tx_valid && tx_ready) tx_n <= tx_n + 1;
    d1_v <= tx_valid && tx_ready && !reset;
    d1_d <= tx_data; d1_i <= tx_n;
    d2_v <= d1_v; d2_d <= d1_d; d2_i <= d1_i;
    d3_v <= d2_v; d3_d <= d2_d; d3_i <= d2_i;
  end

  assign rx_valid = inj_v | (d3_v && d3_i < kill_at);
  assign rx_data  = inj_v ? inj_d : ((d3_i == corrupt_at) ? 8'h00 : d3_d);

  // monitor: TX byte scoreboard, stall stability, run results
  logic       pv = 0, prdy = 0, pdone = 0;
  logic [7:0] pd = 0;
  always @(negedge clock) begin
    if (!reset) begin
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) fail("tx_extra_byte");
        else chk("tx_byte", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
      end
      if (pv && !prdy) begin
        chk("stall_valid", {31'd0, tx_valid}, 32'd1);
        chk("stall_data", {24'd0, tx_data}, {24'd0, pd});
      end
      if (done && !pdone) begin
        if (res_q.size() == 0) fail("done_unexpected");
        else begin
          res_t r;
          r = res_q.pop_front();
          chk("res_pass", {31'd0, pass}, {31'd0, r.p});
          chk("res_err", {16'd0, error_count}, r.err);
          chk("res_pkt", {16'd0, pkt_count}, r.pkt);
          chk("res_timeout", {31'd0, timeout}, {31'd0, r.to});
          chk("res_busy_low", {31'd0, busy}, 32'd0);
        end
      end
    end
    pv    <= tx_valid && !reset;
    prdy  <= tx_ready;
    pd    <= tx_data;
    pdone <= done;
  end

  task automatic push_expect(input logic ep, input int ee, input int epk, input logic eto);
    res_t r;
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < PB; k++)
        tx_q.push_back(k == 0 ? 8'hFF : 8'((p + k) % 256));
    r.p = ep; r.err = ee; r.pkt = epk; r.to = eto;
    res_q.push_back(r);
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_err", {16'd0, error_count}, 32'd0);
    chk("rst_pkt", {16'd0, pkt_count}, 32'd0);
  endtask

  // mode: 0 plain, 1 junk before first header, 2 tx stall + ignored start
  task automatic do_run(input int mode, input logic ep, input int ee,
                        input int epk, input logic eto);
    logic [7:0] junk [3];
    int n;
    junk[0] = 8'h12; junk[1] = 8'h34; junk[2] = 8'h56;
    push_expect(ep, ee, epk, eto);
    if (mode == 1) tx_ready = 1'b0;
    pulse_start();
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_done_clr", {31'd0, done}, 32'd0);
    chk("start_err_clr", {16'd0, error_count}, 32'd0);
    chk("start_pkt_clr", {16'd0, pkt_count}, 32'd0);
    if (mode == 1) begin
      for (int i = 0; i < 3; i++) begin
        inj_v = 1'b1; inj_d = junk[i];
        @(posedge clock); #1;
      end
      inj_v = 1'b0;
      tx_ready = 1'b1;
    end
    if (mode == 2) begin
      n = 0;
      while (tx_n < 30 && n < 500) begin @(posedge clock); #1; n++; end
      if (tx_n < 30) fail("stall_reach");
      tx_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
        start = (i == 3);
        @(posedge clock); #1;
      end
      start = 1'b0;
      tx_ready = 1'b1;
    end
    n = 0;
    while (!done && n < 3000) begin @(posedge clock); #1; n++; end
    if (!done) fail("done_wait");
    repeat (3) @(posedge clock);
    #1 chk("done_held", {31'd0, done}, 32'd1);
    corrupt_at = -1;
    kill_at    = 1 << 30;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 chk_reset_vals();
    reset = 1'b0;
    repeat (2) @(posedge clock);

    do_run(0, 1'b1, 0, 4, 1'b0);              // clean loopback
    corrupt_at = PB + 5;                       // packet 1 byte 5 -> 00
    do_run(0, 1'b0, 1, 4, 1'b0);
    do_run(1, 1'b1, 0, 4, 1'b0);              // junk before first header
    do_run(2, 1'b1, 0, 4, 1'b0);              // tx stall, ignored start
`ifdef BIST_TIMEOUT_EN
    kill_at = 2 * PB;                          // rx stops after packet 2
    do_run(0, 1'b0, 0, 2, 1'b1);
`endif

    // abort mid-run with reset, then a clean run
    push_expect(1'b1, 0, 4, 1'b0);
    pulse_start();
    repeat (40) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 chk_reset_vals();
    reset = 1'b0;
    tx_q.delete();
    res_q.delete();
    repeat (6) @(posedge clock);
    #1 chk("post_rst_done", {31'd0, done}, 32'd0);
    do_run(0, 1'b1, 0, 4, 1'b0);

    if (res_q.size() != 0) fail("res_queue_left");
    if (tx_q.size() != 0) fail("tx_queue_left");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (got hang, required finish)");
    $fatal(1);
  end
endmodule
